arith_rr_scheduler: RTL and testbench

Round-robin scheduler that shares one time-multiplexed 4-bit arithmetic engine among NREQ requesters.
- The engine implements three op classes: scaled add (2*a+b+cin), multiply-accumulate/select, and flag-steered add-mux.
- Each requester issues one op through a valid/ready handshake. The block arbitrates, sequences 1- or 2-cycle execution, and returns a tagged result on a single response channel with backpressure.
- It sits between the arithmetic front-end clients and the downstream result consumer.

---
 rtl/arith_rr_scheduler_if.sv | 36 +++
 rtl/arith_rr_scheduler.sv | 236 +++++++++++++++++++++++
 tb/tb_arith_rr_scheduler.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arith_rr_scheduler_if.sv
// Request/response bundle between the arithmetic clients, the round-robin
// scheduler and the result consumer.
interface arith_rr_scheduler_if #(
    parameter int NREQ = 3,
    parameter int DW   = 4
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high. req_ready is a combinational one-hot grant; rsp_* holds steady
    // while rsp_valid is high and rsp_ready is low.
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [2*NREQ-1:0]  req_op;
    logic [DW*NREQ-1:0] req_a;
    logic [DW*NREQ-1:0] req_b;
    logic [DW*NREQ-1:0] req_c;
    logic [3*NREQ-1:0]  req_x;

    logic               rsp_valid;
    logic               rsp_ready;
    logic [IW-1:0]      rsp_id;
    logic [DW:0]        rsp_out1;
    logic [DW-1:0]      rsp_out2;
    logic               rsp_err;

    modport master (
        output req_valid, req_op, req_a, req_b, req_c, req_x, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_out1, rsp_out2, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_c, req_x, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_out1, rsp_out2, rsp_err
    );
endinterface

// File: rtl/arith_rr_scheduler.sv
// Round-robin scheduler sharing one 4-bit arithmetic engine (ADD2/MAC/STEER).
// Optional performance counters are enabled with `define SCHED_PERF_CNT_EN.
module arith_rr_scheduler #(
    parameter int NREQ = 3,
    parameter int DW   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    arith_rr_scheduler_if.slave  bus,
    output logic                 busy,
    output logic [1:0]           dbg_state
`ifdef SCHED_PERF_CNT_EN
    ,
    output logic [15:0]          grant_cnt,
    output logic [15:0]          stall_cnt
`endif
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] OP_ADD2  = 2'd0;
    localparam logic [1:0] OP_MAC   = 2'd1;
    localparam logic [1:0] OP_STEER = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC1 = 2'd1,
        S_EXEC2 = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_id;
    logic [1:0]      r_op;
    logic [DW-1:0]   r_a;
    logic [DW-1:0]   r_b;
    logic [DW-1:0]   r_c;
    logic [2:0]      r_x;
    logic [DW-1:0]   r_p;
    logic [DW:0]     r_out1;
    logic [DW-1:0]   r_out2;
    logic            r_err;

    logic            w_any;
    logic [IW-1:0]   w_win;
    logic [IW:0]     w_idx;
    logic            w_accept;
    logic [1:0]      w_op;
    logic [DW-1:0]   w_a;
    logic [DW-1:0]   w_b;
    logic [DW-1:0]   w_c;
    logic [2:0]      w_x;

    // Rotating priority: first valid requester at or after the pointer.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = {1'b0, r_ptr} + (IW+1)'(i);
            if (w_idx >= (IW+1)'(NREQ)) begin
                w_idx = w_idx - (IW+1)'(NREQ);
            end
            if (!w_any && bus.req_valid[w_idx[IW-1:0]]) begin
                w_any = 1'b1;
                w_win = w_idx[IW-1:0];
            end
        end
    end

    assign w_accept = (r_state == S_IDLE) && w_any;

    always_comb begin
        bus.req_ready = '0;
        if (rst_n && w_accept) begin
            bus.req_ready[w_win] = 1'b1;
        end
    end

    // Operand mux for the winning requester.
    always_comb begin
        w_op = '0;
        w_a  = '0;
        w_b  = '0;
        w_c  = '0;
        w_x  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == IW'(i)) begin
                w_op = bus.req_op[2*i +: 2];
                w_a  = bus.req_a[DW*i +: DW];
                w_b  = bus.req_b[DW*i +: DW];
                w_c  = bus.req_c[DW*i +: DW];
                w_x  = bus.req_x[3*i +: 3];
            end
        end
    end

    // Engine datapath, evaluated from the latched operands.
    logic [DW:0]   w_add2;
    logic [DW-1:0] w_cb;
    logic [DW-1:0] w_p;
    logic [DW-1:0] w_ab;
    logic [DW-1:0] w_bc;
    logic [DW-1:0] w_ac;
    logic [DW-1:0] w_mac1;
    logic [DW-1:0] w_mac2;
    logic          w_sel1;
    logic          w_sel2;

    always_comb begin
        w_add2 = {r_a, 1'b0} + {1'b0, r_b} + {{DW{1'b0}}, r_x[0]};
        w_cb   = r_c * r_b;
        w_p    = w_cb + {w_cb[DW-2:0], 1'b0};
        w_ab   = r_a + r_b;
        w_bc   = r_b + r_c;
        w_ac   = r_a + r_c;
        w_mac1 = r_a + r_p;
        w_mac2 = (r_b > DW'(2)) ? w_ac : (r_a ^ r_c);
        w_sel1 = r_x[0] | (~r_x[1] & r_x[2]);
        w_sel2 = (r_x[1] & ~r_x[2]) | (r_x[0] & ~r_x[1] & r_x[2]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_next = S_EXEC1;
                end
            end
            S_EXEC1: begin
                if (r_op == OP_MAC) begin
                    w_next = S_EXEC2;
                end else begin
                    w_next = S_RESP;
                end
            end
            S_EXEC2: begin
                w_next = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr  <= '0;
            r_id   <= '0;
            r_op   <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_c    <= '0;
            r_x    <= '0;
            r_p    <= '0;
            r_out1 <= '0;
            r_out2 <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op  <= w_op;
                r_a   <= w_a;
                r_b   <= w_b;
                r_c   <= w_c;
                r_x   <= w_x;
                r_id  <= w_win;
                r_ptr <= (w_win == IW'(NREQ-1)) ? '0 : w_win + 1'b1;
                r_err <= 1'b0;
            end
            if (r_state == S_EXEC1) begin
                case (r_op)
                    OP_ADD2: begin
                        r_out1 <= w_add2;
                        r_out2 <= '0;
                    end
                    OP_MAC: begin
                        r_p <= w_p;
                    end
                    OP_STEER: begin
                        r_out1 <= {1'b0, (w_sel1 ? w_ab : w_bc)};
                        r_out2 <= w_sel2 ? w_bc : w_ab;
                    end
                    default: begin
                        r_out1 <= '0;
                        r_out2 <= '0;
                        r_err  <= 1'b1;
                    end
                endcase
            end
            if (r_state == S_EXEC2) begin
                r_out1 <= {1'b0, w_mac1};
                r_out2 <= w_mac2;
            end
        end
    end

    assign bus.rsp_valid = (r_state == S_RESP);
    assign bus.rsp_id    = r_id;
    assign bus.rsp_out1  = r_out1;
    assign bus.rsp_out2  = r_out2;
    assign bus.rsp_err   = r_err;
    assign busy          = (r_state != S_IDLE);
    assign dbg_state     = r_state;

`ifdef SCHED_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (w_accept && (grant_cnt != 16'hFFFF)) begin
                grant_cnt <= grant_cnt + 16'd1;
            end
            if (bus.rsp_valid && !bus.rsp_ready && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_arith_rr_scheduler.sv
// Randomized scoreboard bench for arith_rr_scheduler: accepts are predicted by a
// reference arbiter, expected responses queued, and a monitor checks each response.
module tb_arith_rr_scheduler;
    localparam int NREQ = 3;
    localparam int DW   = 4;
    localparam int IW   = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    arith_rr_scheduler_if #(.NREQ(NREQ), .DW(DW)) bus ();
    logic       busy;
    logic [1:0] dbg_state;
`ifdef SCHED_PERF_CNT_EN
    logic [15:0] grant_cnt;
    logic [15:0] stall_cnt;
`endif

    arith_rr_scheduler #(.NREQ(NREQ), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .busy      (busy),
        .dbg_state (dbg_state)
`ifdef SCHED_PERF_CNT_EN
        ,
        .grant_cnt (grant_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    // ---------------- scoreboard state ----------------
    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW:0]   o1;
        logic [DW-1:0] o2;
        logic          err;
    } exp_t;

    exp_t exp_q[$];
    int   vcyc_q[$];
    int   grant_log[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_ptr   = 0;
    bit   outstanding = 1'b0;
    int   n_accept = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference model: results straight from the op definitions.
    task automatic model_rsp(input int op, input int a, input int b, input int c, input int x,
                             output int o1, output int o2, output int err, output int lat);
        int x1, x2, x3, p;
        x1 = x & 1; x2 = (x >> 1) & 1; x3 = (x >> 2) & 1;
        err = 0; lat = 2; o1 = 0; o2 = 0;
        case (op)
            0: begin
                o1 = (2*a + b + x1) % 32;
                o2 = 0;
            end
            1: begin
                p   = (3*c*b) % 16;
                o1  = (a + p) % 16;
                o2  = (b > 2) ? (a + c) % 16 : (a ^ c);
                lat = 3;
            end
            2: begin
                o1 = (x1 == 1 || (x2 == 0 && x3 == 1)) ? (a + b) % 16 : (b + c) % 16;
                o2 = ((x2 == 1 && x3 == 0) || (x1 == 1 && x2 == 0 && x3 == 1)) ? (b + c) % 16 : (a + b) % 16;
            end
            default: err = 1;
        endcase
    endtask

    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        for (int i = 0; i < NREQ; i++) begin
            if (v[(p + i) % NREQ]) return (p + i) % NREQ;
        end
        return -1;
    endfunction

    // Accept tracker: predicts grants, checks req_ready/busy, queues expectations.
    always @(negedge clk) begin
        int w, o1, o2, er, lat;
        logic [NREQ-1:0] exp_rdy;
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            vcyc_q.delete();
            m_ptr = 0;
            outstanding = 1'b0;
            n_accept = 0;
            chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
            chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            chk("reset_busy", 32'(busy), 32'd0);
        end else begin
            w = pick(bus.req_valid, m_ptr);
            exp_rdy = '0;
            if (!outstanding && w >= 0) exp_rdy[w] = 1'b1;
            chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
            chk("busy", 32'(busy), 32'(outstanding));
            if (exp_rdy != '0) begin
                model_rsp(int'(bus.req_op[2*w +: 2]), int'(bus.req_a[DW*w +: DW]),
                          int'(bus.req_b[DW*w +: DW]), int'(bus.req_c[DW*w +: DW]),
                          int'(bus.req_x[3*w +: 3]), o1, o2, er, lat);
                e.id = IW'(w); e.o1 = (DW+1)'(o1); e.o2 = DW'(o2); e.err = er[0];
                exp_q.push_back(e);
                vcyc_q.push_back(cyc + lat);
                grant_log.push_back(w);
                m_ptr = (w + 1) % NREQ;
                outstanding = 1'b1;
                n_accept++;
            end else if (outstanding && bus.rsp_valid && bus.rsp_ready) begin
                outstanding = 1'b0;
            end
        end
    end

    // Response monitor: compares every presented response against the queue head.
    bit prev_held = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_held = 1'b0;
        end else begin
            if (bus.rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
                end else begin
                    e = exp_q[0];
                    if (!prev_held) chk("rsp_latency", 32'(cyc), 32'(vcyc_q[0]));
                    chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
                    chk("rsp_out1", 32'(bus.rsp_out1), 32'(e.o1));
                    chk("rsp_out2", 32'(bus.rsp_out2), 32'(e.o2));
                    chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                    if (bus.rsp_ready) begin
                        void'(exp_q.pop_front());
                        void'(vcyc_q.pop_front());
                    end
                end
            end
            prev_held = bus.rsp_valid && !bus.rsp_ready;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(input int r, input int op, input int a, input int b, input int c, input int x);
        bus.req_op[2*r +: 2]  = 2'(op);
        bus.req_a[DW*r +: DW] = DW'(a);
        bus.req_b[DW*r +: DW] = DW'(b);
        bus.req_c[DW*r +: DW] = DW'(c);
        bus.req_x[3*r +: 3]   = 3'(x);
    endtask

    task automatic wait_accept(input int r);
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (bus.req_ready[r]) seen = 1'b1;
        end
        if (!seen) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !outstanding) done = 1'b1;
        end
        if (!done) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic issue(input int r, input int op, input int a, input int b, input int c, input int x);
        @(posedge clk); #1;
        set_req(r, op, a, b, c, x);
        bus.req_valid[r] = 1'b1;
        wait_accept(r);
        @(posedge clk); #1;
        bus.req_valid[r] = 1'b0;
        set_req(r, $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 15),
                $urandom_range(0, 15), $urandom_range(0, 7));
        wait_drain();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "_rsp_id"}, 32'(bus.rsp_id), 32'd0);
        chk({tag, "_rsp_out1"}, 32'(bus.rsp_out1), 32'd0);
        chk({tag, "_rsp_out2"}, 32'(bus.rsp_out2), 32'd0);
        chk({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int p0;
`ifdef SCHED_PERF_CNT_EN
        logic [15:0] s0;
`endif
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.req_op = '0; bus.req_a = '0; bus.req_b = '0; bus.req_c = '0; bus.req_x = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed ops
        issue(0, 0, 15, 15, 0, 3'b001);
        issue(1, 1, 1, 3, 2, 0);
        issue(1, 1, 5, 2, 3, 0);
        issue(2, 2, 4, 5, 6, 3'b100);
        issue(2, 2, 4, 5, 6, 3'b010);
        issue(0, 1, 9, 0, 7, 0);
        issue(1, 1, 6, 11, 0, 0);

        // All requesters valid: grants must rotate
        grant_log.delete();
        p0 = m_ptr;
        @(posedge clk); #1;
        for (int r = 0; r < NREQ; r++) set_req(r, 0, $urandom_range(0, 15), $urandom_range(0, 15), 0, $urandom_range(0, 7));
        bus.req_valid = '1;
        for (int i = 0; i < 100 && grant_log.size() < 5; i++) begin
            @(posedge clk); #1;
            for (int r = 0; r < NREQ; r++) set_req(r, 0, $urandom_range(0, 15), $urandom_range(0, 15), 0, $urandom_range(0, 7));
        end
        bus.req_valid = '0;
        wait_drain();
        chk("rr_count", 32'(grant_log.size() >= 5), 32'd1);
        for (int i = 0; i < 5 && i < grant_log.size(); i++) chk("rr_order", 32'(grant_log[i]), 32'((p0 + i) % NREQ));

        // Backpressure: hold rsp_ready low for 5 cycles
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        set_req(0, 2, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7));
        bus.req_valid[0] = 1'b1;
        wait_accept(0);
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        for (int i = 0; i < 20 && !bus.rsp_valid; i++) @(negedge clk);
        chk("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
`ifdef SCHED_PERF_CNT_EN
        s0 = stall_cnt;
`endif
        repeat (5) @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        @(negedge clk);
`ifdef SCHED_PERF_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), 32'(s0 + 16'd5));
`endif
        wait_drain();

        // Randomized traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            for (int r = 0; r < NREQ; r++) begin
                bus.req_valid[r] = ($urandom_range(0, 1) == 1);
                set_req(r, $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 15),
                        $urandom_range(0, 15), $urandom_range(0, 7));
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        wait_drain();
`ifdef SCHED_PERF_CNT_EN
        chk("grant_cnt", 32'(grant_cnt), 32'(n_accept));
`endif

        // Illegal op, then reset during a MAC in EXEC2
        issue(2, 3, 7, 8, 9, 3'b111);
        @(posedge clk); #1;
        set_req(1, 1, 5, 6, 7, 0);
        bus.req_valid[1] = 1'b1;
        wait_accept(1);
        @(posedge clk); #1;
        bus.req_valid[1] = 1'b0;
        @(posedge clk); #1;
        chk("pre_reset_state_exec2", 32'(dbg_state), 32'd2);
        rst_n = 1'b0;
        bus.req_valid = '1;
        @(negedge clk);
        check_all_zero("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_grant", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_valid = '0;
        wait_drain();
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
